lane_node_gene_tx: RTL

//  Producer side of the lane gene stream: emits fresh node genes into a lane after a scan.
//  On a start pulse in emit phase, allocates COUNT consecutive node IDs starting at base_id+1.

---
 rtl/neat_gene_pkg.sv | 34 +++
 rtl/neat_node_gene_pack.sv | 29 ++
 rtl/lane_node_gene_tx.sv | 116 +++++++++++
 3 files changed

// File: rtl/neat_gene_pkg.sv
// Shared gene-format constants, lane phase/layer codes and the node-gene emitter FSM encoding.
// Gene parity bit is controlled by the LANE_GENE_PARITY_EN macro (see neat_node_gene_pack).
package neat_gene_pkg;

  localparam int DEF_GENE_SZ = 64;
  localparam int DEF_ATTR_SZ = 8;
  localparam int LAYER_W     = 2;

  function automatic int node_id_lsb(input int attr_sz);
    return 5 * attr_sz;
  endfunction

  function automatic int layer_lsb(input int attr_sz);
    return 7 * attr_sz - 3;
  endfunction

  localparam int NODE_ID_LSB = 5 * DEF_ATTR_SZ;
  localparam int LAYER_LSB   = 7 * DEF_ATTR_SZ - 3;
  localparam int ENABLE_BIT  = DEF_GENE_SZ - 1;

  localparam logic [1:0] LAYER_HIDDEN = 2'b00;
  localparam logic [1:0] LAYER_INPUT  = 2'b01;
  localparam logic [1:0] LAYER_OUTPUT = 2'b10;

  localparam logic [1:0] PH_SCAN = 2'b00;
  localparam logic [1:0] PH_EMIT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_FIN  = 2'b10
  } gtx_state_e;

endpackage

// File: rtl/neat_node_gene_pack.sv
// Combinational node-gene packer: node_id + layer -> gene word with the enable bit set.
// With LANE_GENE_PARITY_EN defined, bit 0 carries even parity over the upper bits.
module neat_node_gene_pack
  import neat_gene_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8
) (
  input  logic [ATTR_SZ-1:0] node_id,
  input  logic [LAYER_W-1:0] layer,
  output logic [GENE_SZ-1:0] gene
);

  localparam int NID_LSB = node_id_lsb(ATTR_SZ);
  localparam int LAY_LSB = layer_lsb(ATTR_SZ);

  always_comb begin
    gene                        = '0;
    gene[GENE_SZ-1]             = 1'b1;
    gene[NID_LSB +: ATTR_SZ]    = node_id;
    gene[LAY_LSB +: LAYER_W]    = layer;
`ifdef LANE_GENE_PARITY_EN
    gene[0]                     = ^gene[GENE_SZ-1:1];
`else
    gene[0]                     = 1'b0;
`endif
  end

endmodule

// File: rtl/lane_node_gene_tx.sv
// Lane node-gene producer: allocates COUNT consecutive IDs above base_id and streams packed genes.
// Parity in gene bit 0 is enabled by the LANE_GENE_PARITY_EN macro.
module lane_node_gene_tx
  import neat_gene_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8,
  parameter int CNT_SZ  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         state,
  input  logic               start,
  input  logic [ATTR_SZ-1:0] base_id,
  input  logic [1:0]         layer_in,
  input  logic [CNT_SZ-1:0]  count,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               gene_valid,
  input  logic               gene_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [ATTR_SZ-1:0] last_id
);

  gtx_state_e          state_q, state_d;
  logic [ATTR_SZ-1:0]  next_id_q, next_id_d;
  logic [ATTR_SZ-1:0]  last_id_q, last_id_d;
  logic [CNT_SZ-1:0]   rem_q, rem_d;
  logic [1:0]          layer_q, layer_d;
  logic                ovf_q, ovf_d;
  logic                start_ok;
  logic [GENE_SZ-1:0]  gene_packed;

  assign start_ok = start && (state == PH_EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      next_id_q <= '0;
      last_id_q <= '0;
      rem_q     <= '0;
      layer_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      next_id_q <= next_id_d;
      last_id_q <= last_id_d;
      rem_q     <= rem_d;
      layer_q   <= layer_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    next_id_d = next_id_q;
    last_id_d = last_id_q;
    rem_d     = rem_q;
    layer_d   = layer_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          last_id_d = base_id;
          layer_d   = layer_in;
          rem_d     = count;
          next_id_d = base_id + 1'b1;
          ovf_d     = 1'b0;
          if (count == '0) begin
            state_d = ST_FIN;
          end else if (&base_id) begin
            // No ID is left above an all-ones base: nothing can be allocated.
            ovf_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (gene_ready) begin
          last_id_d = next_id_q;
          rem_d     = rem_q - 1'b1;
          next_id_d = next_id_q + 1'b1;
          if (rem_q == CNT_SZ'(1)) begin
            state_d = ST_FIN;
          end else if (&next_id_q) begin
            // More genes wanted but the ID space is spent; stop rather than wrap.
            ovf_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  neat_node_gene_pack #(
    .GENE_SZ (GENE_SZ),
    .ATTR_SZ (ATTR_SZ)
  ) u_pack (
    .node_id (next_id_q),
    .layer   (layer_q),
    .gene    (gene_packed)
  );

  assign gene_valid = (state_q == ST_SEND);
  assign gene_out   = gene_valid ? gene_packed : '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign overflow   = ovf_q;
  assign last_id    = last_id_q;

endmodule
